cpu_hazard_scoreboard: RTL and testbench

Pipeline hazard scoreboard and interlock controller for the SLURM32 core. Sits beside `cpu_decode` and tracks register writes still in flight in execute, memory and writeback. It compares them against the decoder's regA/regB read selects. From that comparison it drives operand-forwarding selects, load-use stall, memory-wait freeze and a saturating stall-cycle counter.

---
 rtl/cpu_hazard_scoreboard_if.sv | 31 +++
 rtl/cpu_hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_cpu_hazard_scoreboard.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_hazard_scoreboard_if.sv
// Decode-slot / hazard-control bundle between cpu_decode and the hazard scoreboard.
// The decoder drives the selects and issue info; the scoreboard returns the interlock and forwarding controls.
interface cpu_hazard_scoreboard_if #(
  parameter int REGISTER_BITS = 8,
  parameter int COUNT_BITS    = 16
);
  logic [REGISTER_BITS-1:0] regA_sel;
  logic [REGISTER_BITS-1:0] regB_sel;
  logic                     issue_valid;
  logic                     issue_wr;
  logic [REGISTER_BITS-1:0] issue_dest;
  logic                     issue_is_load;
  logic                     flush;
  logic                     mem_ready;
  logic                     stall;
  logic                     freeze;
  logic [1:0]               fwdA_sel;
  logic [1:0]               fwdB_sel;
  logic [COUNT_BITS-1:0]    stall_count;
  logic                     mem_wait;

  modport master (
    output regA_sel, regB_sel, issue_valid, issue_wr, issue_dest, issue_is_load, flush, mem_ready,
    input  stall, freeze, fwdA_sel, fwdB_sel, stall_count, mem_wait
  );

  modport slave (
    input  regA_sel, regB_sel, issue_valid, issue_wr, issue_dest, issue_is_load, flush, mem_ready,
    output stall, freeze, fwdA_sel, fwdB_sel, stall_count, mem_wait
  );
endinterface

// File: rtl/cpu_hazard_scoreboard.sv
// Tracks register writes in execute/memory/writeback and derives forwarding selects,
// load-use stall, memory-wait freeze and a saturating stall-cycle counter.
module cpu_hazard_scoreboard #(
  parameter int REGISTER_BITS = 8,
  parameter int COUNT_BITS    = 16
) (
  input logic                    CLK,
  input logic                    RSTb,
  cpu_hazard_scoreboard_if.slave bus
);

  typedef enum logic {RUN, WAIT_MEM} state_t;

  state_t state_reg, state_next;

  // Slot index 0 = execute, 1 = memory, 2 = writeback.
  logic [2:0]               valid_reg, valid_next;
  logic [2:0]               load_reg, load_next;
  logic [REGISTER_BITS-1:0] dest_reg [3];
  logic [REGISTER_BITS-1:0] dest_next [3];
  logic [COUNT_BITS-1:0]    count_reg, count_next;

  logic [2:0]               match_a, match_b;
  logic                     hazard, freeze, stall;
  logic                     entry_valid, entry_load;
  logic [REGISTER_BITS-1:0] entry_dest;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_match
      assign match_a[gi] = valid_reg[gi] && (dest_reg[gi] == bus.regA_sel) && (bus.regA_sel != '0);
      assign match_b[gi] = valid_reg[gi] && (dest_reg[gi] == bus.regB_sel) && (bus.regB_sel != '0);
    end
  endgenerate

  // A load still in execute has no data yet, so it can only interlock, never forward.
  function automatic logic [1:0] fwd_sel(input logic [2:0] m, input logic s1_load);
    if (m[0] && !s1_load) return 2'd1;
    else if (m[1])        return 2'd2;
    else if (m[2])        return 2'd3;
    else                  return 2'd0;
  endfunction

  assign hazard = load_reg[0] && (match_a[0] || match_b[0]);
  assign freeze = valid_reg[1] && load_reg[1] && !bus.mem_ready;
  assign stall  = hazard && !bus.flush && !freeze;

  assign entry_valid = bus.issue_valid && bus.issue_wr && !bus.flush && !stall;
  assign entry_dest  = entry_valid ? bus.issue_dest : '0;
  assign entry_load  = entry_valid && bus.issue_is_load;

  always_comb begin
    valid_next = valid_reg;
    load_next  = load_reg;
    dest_next  = dest_reg;
    if (!freeze) begin
      valid_next   = {valid_reg[1:0], entry_valid};
      load_next    = {load_reg[1:0], entry_load};
      dest_next[0] = entry_dest;
      dest_next[1] = dest_reg[0];
      dest_next[2] = dest_reg[1];
    end
  end

  always_comb begin
    count_next = count_reg;
    if ((stall || freeze) && (count_reg != '1))
      count_next = count_reg + {{(COUNT_BITS-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (freeze)        state_next = WAIT_MEM;
      WAIT_MEM: if (bus.mem_ready) state_next = RUN;
      default:                     state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg <= RUN;
      valid_reg <= '0;
      load_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      load_reg  <= load_next;
      count_reg <= count_next;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_dest
      always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) dest_reg[gi] <= '0;
        else       dest_reg[gi] <= dest_next[gi];
      end
    end
  endgenerate

  assign bus.stall       = stall;
  assign bus.freeze      = freeze;
  assign bus.fwdA_sel    = fwd_sel(match_a, load_reg[0]);
  assign bus.fwdB_sel    = fwd_sel(match_b, load_reg[0]);
  assign bus.stall_count = count_reg;
  assign bus.mem_wait    = (state_reg == WAIT_MEM);

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed-vector bench for cpu_hazard_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cpu_hazard_scoreboard;

  logic CLK = 1'b0;
  logic RSTb = 1'b0;
  always #5 CLK = ~CLK;

  cpu_hazard_scoreboard_if #(.REGISTER_BITS(8), .COUNT_BITS(16)) bus();

  cpu_hazard_scoreboard #(.REGISTER_BITS(8), .COUNT_BITS(16)) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  typedef struct {
    string tag;
    int    fa;   // -1: don't care
    int    fb;
    int    st;
    int    fr;
    int    mw;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input string fld, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.fa >= 0) chk(mon_e.tag, "fwdA_sel", int'(bus.fwdA_sel), mon_e.fa);
      if (mon_e.fb >= 0) chk(mon_e.tag, "fwdB_sel", int'(bus.fwdB_sel), mon_e.fb);
      chk(mon_e.tag, "stall", int'(bus.stall), mon_e.st);
      chk(mon_e.tag, "freeze", int'(bus.freeze), mon_e.fr);
      chk(mon_e.tag, "mem_wait", int'(bus.mem_wait), mon_e.mw);
      chk(mon_e.tag, "stall_count", int'(bus.stall_count), mon_e.cnt);
      $display("check %-10s fwdA=%0d fwdB=%0d stall=%0d freeze=%0d count=%0d",
               mon_e.tag, bus.fwdA_sel, bus.fwdB_sel, bus.stall, bus.freeze, bus.stall_count);
    end
  end

  task automatic step(input logic rstb, input logic iv, input logic wr, input logic [7:0] dst,
                      input logic ld, input logic [7:0] a, input logic [7:0] b, input logic fl,
                      input logic mr, input int efa, input int efb, input int es, input int ef,
                      input int emw, input int ecnt, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    RSTb              = rstb;
    bus.issue_valid   = iv;
    bus.issue_wr      = wr;
    bus.issue_dest    = dst;
    bus.issue_is_load = ld;
    bus.regA_sel      = a;
    bus.regB_sel      = b;
    bus.flush         = fl;
    bus.mem_ready     = mr;
    e.tag = tag; e.fa = efa; e.fb = efb; e.st = es; e.fr = ef; e.mw = emw; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bus.issue_valid = 0; bus.issue_wr = 0; bus.issue_dest = 0; bus.issue_is_load = 0;
    bus.regA_sel = 0; bus.regB_sel = 0; bus.flush = 0; bus.mem_ready = 1;
    repeat (2) @(posedge CLK);
    //   rstb iv wr dst ld  a   b  fl mr  fa  fb st fr mw cnt  tag
    step(0, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "rst_init");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "rst_rel");
    // ALU forwarding through execute, memory, writeback
    step(1, 1, 1, 5,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "alu_iss");
    step(1, 0, 0, 0,  0, 5,  0,  0, 1,  1,  0, 0, 0, 0, 0,   "alu_s1");
    step(1, 0, 0, 0,  0, 5,  0,  0, 1,  2,  0, 0, 0, 0, 0,   "alu_s2");
    step(1, 0, 0, 0,  0, 5,  0,  0, 1,  3,  0, 0, 0, 0, 0,   "alu_s3");
    step(1, 0, 0, 0,  0, 5,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "alu_gone");
    // register 0 never matches
    step(1, 1, 1, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "r0_iss");
    step(1, 1, 1, 9,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "r0_s1");
    step(1, 0, 0, 0,  0, 0,  9,  0, 1,  0,  1, 0, 0, 0, 0,   "r0_s2");
    // back-to-back independent instructions
    step(1, 1, 1, 1,  0, 2,  3,  0, 1,  0,  0, 0, 0, 0, 0,   "indep1");
    step(1, 1, 1, 2,  0, 3,  4,  0, 1,  0,  0, 0, 0, 0, 0,   "indep2");
    step(1, 1, 1, 3,  0, 4,  5,  0, 1,  0,  0, 0, 0, 0, 0,   "indep3");
    step(1, 0, 0, 0,  0, 1,  2,  0, 1,  3,  2, 0, 0, 0, 0,   "indep_fwd");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "idle1");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "idle2");
    // youngest-first priority with r6 in several slots
    step(1, 1, 1, 6,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "prio_a");
    step(1, 1, 1, 6,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "prio_b");
    step(1, 1, 1, 6,  0, 6,  0,  0, 1,  1,  0, 0, 0, 0, 0,   "prio_c");
    step(1, 0, 0, 0,  0, 6,  6,  0, 1,  1,  1, 0, 0, 0, 0,   "prio_123");
    step(1, 0, 0, 0,  0, 6,  0,  0, 1,  2,  0, 0, 0, 0, 0,   "prio_23");
    step(1, 0, 0, 0,  0, 0,  6,  0, 1,  0,  3, 0, 0, 0, 0,   "prio_3");
    // load-use: one stall cycle, then forward from memory
    step(1, 1, 1, 7,  1, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "ld_iss");
    step(1, 1, 1, 8,  0, 0,  7,  0, 1,  0, -1, 1, 0, 0, 0,   "ld_stall");
    step(1, 1, 1, 8,  0, 0,  7,  0, 1,  0,  2, 0, 0, 0, 1,   "ld_fwd2");
    step(1, 0, 0, 0,  0, 8,  7,  0, 1,  1,  3, 0, 0, 0, 1,   "ld_fwd3");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 1,   "idle3");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 1,   "idle4");
    // memory wait: load r3 in memory with 4 cycles of mem_ready=0
    step(1, 1, 1, 3,  1, 0,  0,  0, 1,  0,  0, 0, 0, 0, 1,   "mw_ld");
    step(1, 1, 1, 4,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 1,   "mw_alu");
    step(1, 1, 1, 10, 0, 4,  3,  0, 0,  1,  2, 0, 1, 0, 1,   "mw_f1");
    step(1, 1, 1, 10, 0, 4,  3,  0, 0,  1,  2, 0, 1, 1, 2,   "mw_f2");
    step(1, 1, 1, 10, 0, 4,  3,  0, 0,  1,  2, 0, 1, 1, 3,   "mw_f3");
    step(1, 1, 1, 10, 0, 4,  3,  0, 0,  1,  2, 0, 1, 1, 4,   "mw_f4");
    step(1, 1, 1, 10, 0, 4,  3,  0, 1,  1,  2, 0, 0, 1, 5,   "mw_go");
    step(1, 0, 0, 0,  0, 10, 3,  0, 1,  1,  3, 0, 0, 0, 5,   "mw_resume");
    step(1, 0, 0, 0,  0, 4,  0,  0, 1,  3,  0, 0, 0, 0, 5,   "mw_s3");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 5,   "idle5");
    // flush coinciding with a load-use hazard
    step(1, 1, 1, 11, 1, 0,  0,  0, 1,  0,  0, 0, 0, 0, 5,   "fl_ld");
    step(1, 1, 1, 12, 0, 11, 0,  1, 1, -1,  0, 0, 0, 0, 5,   "fl_haz");
    step(1, 0, 0, 0,  0, 12, 11, 0, 1,  0,  2, 0, 0, 0, 5,   "fl_bubble");
    step(1, 0, 0, 0,  0, 0,  11, 0, 1,  0,  3, 0, 0, 0, 5,   "fl_s3");
    // asynchronous reset with slots occupied
    step(1, 1, 1, 13, 0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 5,   "rs_a");
    step(1, 1, 1, 14, 1, 0,  0,  0, 1,  0,  0, 0, 0, 0, 5,   "rs_b");
    step(1, 1, 1, 15, 0, 14, 0,  0, 1, -1,  0, 1, 0, 0, 5,   "rs_stall");
    step(0, 0, 0, 0,  0, 14, 13, 0, 0,  0,  0, 0, 0, 0, 0,   "rs_assert");
    step(1, 0, 0, 0,  0, 14, 13, 0, 0,  0,  0, 0, 0, 0, 0,   "rs_release");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "rs_idle");
    // saturation: hold a load in memory for 70000 cycles
    step(1, 1, 1, 3,  1, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "sat_ld");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 0,   "sat_s2");
    @(posedge CLK);
    #1;
    bus.mem_ready = 0;
    repeat (69999) @(posedge CLK);
    step(1, 0, 0, 0,  0, 0,  0,  0, 0,  0,  0, 0, 1, 1, 65535, "sat_hold");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 1, 65535, "sat_rel");
    step(1, 0, 0, 0,  0, 0,  0,  0, 1,  0,  0, 0, 0, 0, 65535, "sat_end");
    repeat (2) @(negedge CLK);
    chk("drain", "pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
